// File: rtl/count_enable_pkg.sv
// rtl/count_enable_pkg.sv - shared types and widths for the count enable generator
package count_enable_pkg;

  // Run-control FSM encoding
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ARM  = 2'b01,
    RUN  = 2'b10
  } cen_state_t;

  // Debounce counter width sized for the largest legal DEBOUNCE_CYCLES (255),
  // so one width serves every legal parameterisation.
  localparam int DEBOUNCE_CYCLES_MAX = 255;
  localparam int DB_CNT_W = $clog2(DEBOUNCE_CYCLES_MAX + 1);

endpackage

// File: rtl/evt_debounce.sv
// rtl/evt_debounce.sv - synchroniser, debounce filter and rise detector for the raw event line
module evt_debounce
  import count_enable_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic evt_in,
  output logic level,
  output logic rise
);

  // The level flips on the edge where the counter would step to DEBOUNCE_CYCLES,
  // so the counter itself only ever holds 0..DEBOUNCE_CYCLES-1.
  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                sync1;
  logic                evt_s;
  logic                level_d;
  logic [DB_CNT_W-1:0] cnt;

  // Two-flop synchroniser, stability counter and delayed level for edge detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1   <= 1'b0;
      evt_s   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= evt_in;
      evt_s   <= sync1;
      level_d <= level;
      if (evt_s != level) begin
        if (cnt == DB_LAST) begin
          level <= evt_s;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // High for the single cycle after the debounced level has gone 0 to 1
  assign rise = level & ~level_d;

endmodule

// File: rtl/count_enable_gen.sv
// rtl/count_enable_gen.sv - run-controlled, prescaled enable pulse generator for the event counter
module count_enable_gen
  import count_enable_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int PRESCALE_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  evt_in,
  input  logic                  start,
  input  logic                  stop,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  enable,
  output logic                  busy
);

  cen_state_t            state;
  logic [PRESCALE_W-1:0] pre_lat;
  logic [PRESCALE_W-1:0] pre_cnt;
  logic                  level;
  logic                  rise;

  evt_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk    (clk),
    .reset_n(reset_n),
    .evt_in (evt_in),
    .level  (level),
    .rise   (rise)
  );

  // Run-control FSM, prescale latch/counter and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      pre_lat <= '0;
      pre_cnt <= '0;
      enable  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      enable <= 1'b0;
      case (state)
        IDLE: begin
          // stop beats a simultaneous start
          if (start && !stop) begin
            state   <= ARM;
            pre_lat <= prescale;
            pre_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        ARM: begin
          // wait for the line to be low so an already-high line is not counted
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!level) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (rise) begin
            if (pre_cnt == pre_lat) begin
              enable  <= 1'b1;
              pre_cnt <= '0;
            end else begin
              pre_cnt <= pre_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
